// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared load/store port types, byte-enable constants and lane merge helper.
package mem_if_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE    = 4'b0001;
    function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
        logic [31:0] m;
        m = old_w;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return m;
    endfunction
endpackage

// File: rtl/dm_word_array.sv
// dm_word_array: reset-cleared word array with a byte-lane write port and one async read port.
module dm_word_array
    import mem_if_pkg::*;
#(
    parameter int DEPTH = 3072,
    parameter int IDX_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    logic [31:0] mem [DEPTH];
    // Indices past DEPTH read as zero; the responder never writes them.
    assign rdata = ({1'b0, idx} < (IDX_W+1)'(DEPTH)) ? mem[idx] : '0;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[idx] <= merge_be(mem[idx], wdata, be);
        end
endmodule

// File: rtl/dm_responder.sv
// dm_responder: slow data-memory responder (valid/ready request, programmable wait, held response).
// Define DM_RESPONDER_TRACE_EN to print one line per committed store.
module dm_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 3072,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0] be_q;
    logic idle, go_resp, err, wr_en, cur_we;
    logic [31:0] cur_addr, cur_wdata, word;
    logic [3:0] cur_be;
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    // With zero wait the request commits on its accept edge, so it is taken straight from the port.
    always_comb begin
        idle = state == IDLE;
        cur_we = idle ? req_we : we_q;
        cur_addr = idle ? req_addr : addr_q;
        cur_be = idle ? req_be : be_q;
        cur_wdata = idle ? req_wdata : wdata_q;
        err = ({2'b00, cur_addr[31:2]} >= DEPTH_L)
            || (cur_be == BE_WORD && cur_addr[1:0] != 2'b00)
            || ((cur_be == BE_HALF_LO || cur_be == BE_HALF_HI) && cur_addr[0]);
        state_n = state;
        go_resp = 1'b0;
        if (idle) begin
            if (req_valid) begin
                state_n = WAIT_CYCLES == 0 ? RESP : WAIT;
                go_resp = WAIT_CYCLES == 0;
            end
        end else if (state == WAIT) begin
            if (cnt == CNT_W'(WAIT_CYCLES - 1)) begin
                state_n = RESP;
                go_resp = 1'b1;
            end
        end else if (rsp_ready) begin
            state_n = IDLE;
        end
        wr_en = go_resp && cur_we && !err;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            we_q <= 1'b0;
            addr_q <= '0;
            be_q <= '0;
            wdata_q <= '0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= (state == WAIT && state_n == WAIT) ? cnt + 1'b1 : '0;
            if (idle && req_valid) begin
                we_q <= req_we;
                addr_q <= req_addr;
                be_q <= req_be;
                wdata_q <= req_wdata;
            end
            if (go_resp) begin
                rsp_rdata <= (err || cur_we) ? '0 : word;
                rsp_err <= err;
            end
        end
    dm_word_array #(.DEPTH(DEPTH_WORDS), .IDX_W(IDX_W)) u_mem (
        .clk(clk),
        .reset(reset),
        .we(wr_en),
        .idx(cur_addr[IDX_W+1:2]),
        .be(cur_be),
        .wdata(cur_wdata),
        .rdata(word)
    );
`ifdef DM_RESPONDER_TRACE_EN
    logic [31:0] pc_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) pc_q <= '0;
        else if (idle && req_valid) pc_q <= req_pc;
    always_ff @(posedge clk)
        if (reset && wr_en && cur_be != 4'b0000)
            $display("%d@%h: *%h <= %h", $time, idle ? req_pc : pc_q, {cur_addr[31:2], 2'b00}, merge_be(word, cur_wdata, cur_be));
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: randomized check of two responders (wait 1 and wait 0) against a byte-level memory model.
module tb_dm_responder;
    localparam int DEPTH = 3072;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req_valid [2], req_ready [2], req_we [2], rsp_valid [2], rsp_ready [2], rsp_err [2];
    logic [3:0] req_be [2];
    logic [31:0] req_addr [2], req_wdata [2], req_pc [2], rsp_rdata [2];
    logic [7:0] mem_b [2][4*DEPTH];
    int total = 0, bad = 0, cyc = 0;
    int last_acc [2];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    dm_responder #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_be(req_be[0]), .req_wdata(req_wdata[0]),
        .req_pc(req_pc[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );
    dm_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_be(req_be[1]), .req_wdata(req_wdata[1]),
        .req_pc(req_pc[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );
    function automatic int wc(input int k);
        return k == 0 ? 1 : 0;
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic clear_model();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4*DEPTH; i++) mem_b[k][i] = 8'h00;
    endtask
    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h3000 + ($urandom & 32'h0000_0FFC);
        if (r == 1) return 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
        return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction
    task automatic txn(input int k, input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input int bp, input bit period);
        logic e;
        logic [31:0] exp_rd;
        int n, acc, base;
        e = (addr >> 2) >= DEPTH || (be == 4'hF && addr[1:0] != 0) || ((be == 4'h3 || be == 4'hC) && addr[0]);
        base = e ? 0 : int'(addr >> 2) * 4;
        exp_rd = 0;
        if (!e && !we)
            for (int i = 0; i < 4; i++) exp_rd[8*i +: 8] = mem_b[k][base + i];
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_idle", req_ready[k], 1);
        req_valid[k] = 1; req_we[k] = we; req_addr[k] = addr; req_be[k] = be;
        req_wdata[k] = wdata; req_pc[k] = $urandom;
        @(posedge clk); #1;
        acc = cyc;
        req_valid[k] = 0;
        if (period) chk("accept_period", acc - last_acc[k], wc(k) + 2);
        last_acc[k] = acc;
        n = 1;
        while (!rsp_valid[k] && n < 50) begin
            chk("req_ready_busy", req_ready[k], 0);
            @(posedge clk); #1; n++;
        end
        chk("latency", n, wc(k) + 1);
        chk("rdata", rsp_rdata[k], exp_rd);
        chk("err", rsp_err[k], e);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", rsp_valid[k], 1);
            chk("bp_rdata", rsp_rdata[k], exp_rd);
            chk("bp_req_ready", req_ready[k], 0);
        end
        rsp_ready[k] = 1;
        @(posedge clk); #1;
        rsp_ready[k] = 0;
        chk("ready_after", req_ready[k], 1);
        chk("valid_after", rsp_valid[k], 0);
        if (!e && we)
            for (int i = 0; i < 4; i++) if (be[i]) mem_b[k][base + i] = wdata[8*i +: 8];
    endtask
    initial begin
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 0; req_we[k] = 0; req_addr[k] = 0; req_be[k] = 0;
            req_wdata[k] = 0; req_pc[k] = 0; rsp_ready[k] = 0; last_acc[k] = 0;
        end
        clear_model();
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", rsp_valid[k], 0);
            chk("rst_ready", req_ready[k], 1);
            chk("rst_rdata", rsp_rdata[k], 0);
            chk("rst_err", rsp_err[k], 0);
        end
        reset = 1;
        @(posedge clk); #1;
        txn(0, 0, 32'h0, 4'hF, 0, 0, 0);
        txn(0, 1, 32'h10, 4'hF, 32'h1234_5678, 0, 0);
        txn(0, 0, 32'h10, 4'hF, 0, 0, 0);
        txn(0, 1, 32'h10, 4'b0010, 32'h0000_AB00, 0, 0);
        txn(0, 0, 32'h10, 4'hF, 0, 5, 0);
        txn(0, 0, 32'h3000, 4'hF, 0, 0, 0);
        txn(0, 1, 32'h12, 4'hF, 32'hFFFF_FFFF, 0, 0);
        txn(0, 1, 32'h10, 4'h0, 32'hFFFF_FFFF, 0, 0);
        txn(0, 0, 32'h10, 4'h0, 0, 0, 0);
        txn(0, 1, 32'h20, 4'hF, 32'hDEAD_BEEF, 0, 0);
        txn(1, 1, 32'h20, 4'hF, 32'hCAFE_F00D, 0, 0);
        req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 32'h20; req_be[0] = 4'hF; req_wdata[0] = 32'h5555_AAAA;
        @(posedge clk); #1;
        req_valid[0] = 0;
        chk("wait_ready", req_ready[0], 0);
        reset = 0;
        #1;
        chk("abort_valid", rsp_valid[0], 0);
        chk("abort_ready", req_ready[0], 1);
        clear_model();
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        txn(0, 0, 32'h20, 4'hF, 0, 0, 0);
        txn(1, 0, 32'h20, 4'hF, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            txn(k, 1, 32'h4, 4'hF, $urandom, 0, 0);
            for (int j = 0; j < 6; j++) txn(k, j[0], 32'h4, 4'hF, $urandom, 0, 1);
        end
        for (int j = 0; j < 80; j++)
            txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), rand_addr(), 4'($urandom), $urandom, $urandom_range(0, 2), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
